// File: rtl/idecode_pkg.sv
// Shared types for the decode queue: class encodings, special opcodes, record.
// IDECODE_MUL_EN enables multiply-opcode decode in idecode_fields.
package idecode_pkg;

   typedef enum logic [1:0] {
      CLS_DIMM = 2'b00,
      CLS_DREG = 2'b01,
      CLS_LDST = 2'b10,
      CLS_BR   = 2'b11
   } cls_e;

   localparam logic [6:0] OP_HALT = 7'b1101000;
   localparam logic [6:0] OP_MUL0 = 7'b0010000;
   localparam logic [6:0] OP_MUL1 = 7'b0110000;
   localparam logic [6:0] OP_MUL2 = 7'b0011000;
   localparam logic [6:0] OP_MUL3 = 7'b0111000;

   // imm kept at 16 bits; sext tells the queue how to widen it to DW
   typedef struct packed {
      cls_e        cls;
      logic        set_flags;
      logic [2:0]  alu_fn;
      logic [3:0]  br_cond;
      logic [3:0]  dest;
      logic [3:0]  src1;
      logic [3:0]  src2;
      logic        reg_write;
      logic [15:0] imm;
      logic        sext;
      logic        halt;
      logic        mul_trigger;
      logic [1:0]  mul_type;
   } rec_t;

endpackage

// File: rtl/idecode_fields.sv
// Combinational instruction -> decoded record.
// Multiply opcodes are recognised only when IDECODE_MUL_EN is defined.
module idecode_fields
   import idecode_pkg::*;
(
   input  logic [31:0] instruction,
   output rec_t        rec
);

   logic [6:0] op;
   logic       unused;

   assign op     = instruction[31:25];
   assign unused = instruction[29];

   always_comb begin
      rec     = '0;
      rec.cls = cls_e'(instruction[31:30]);
      unique case (rec.cls)
         CLS_BR: begin
            rec.br_cond = instruction[24:21];
            rec.src1    = instruction[20:17];
            rec.src2    = instruction[16:13];
            rec.imm     = instruction[15:0];
            rec.sext    = 1'b1;
         end
         CLS_LDST: begin
            rec.dest = instruction[24:21];
            rec.src1 = instruction[20:17];
            rec.imm  = instruction[15:0];
         end
         CLS_DREG: begin
            rec.set_flags = instruction[28];
            rec.alu_fn    = instruction[27:25];
            rec.dest      = instruction[24:21];
            rec.src1      = instruction[20:17];
            rec.src2      = instruction[16:13];
            rec.reg_write = 1'b1;
         end
         CLS_DIMM: begin
            rec.set_flags = instruction[28];
            rec.alu_fn    = instruction[27:25];
            rec.dest      = instruction[24:21];
            rec.src1      = instruction[20:17];
            rec.imm       = instruction[15:0];
            rec.reg_write = 1'b1;
         end
      endcase
      rec.halt = (op == OP_HALT);
`ifdef IDECODE_MUL_EN
      case (op)
         OP_MUL0: begin rec.mul_trigger = 1'b1; rec.mul_type = 2'd0; end
         OP_MUL1: begin rec.mul_trigger = 1'b1; rec.mul_type = 2'd1; end
         OP_MUL2: begin rec.mul_trigger = 1'b1; rec.mul_type = 2'd2; end
         OP_MUL3: begin rec.mul_trigger = 1'b1; rec.mul_type = 2'd3; end
         default: ;
      endcase
`else
      rec.mul_trigger = 1'b0;
      rec.mul_type    = 2'd0;
`endif
   end

endmodule

// File: rtl/idecode_queue.sv
// Decode stage with a DEPTH-entry queue of decoded records and sticky halt.
// IDECODE_MUL_EN (see idecode_fields) adds multiply-opcode decode.
module idecode_queue
   import idecode_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int DW    = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [31:0]            instruction,
   input  logic                   flush,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [1:0]             cls,
   output logic                   set_flags,
   output logic [2:0]             alu_fn,
   output logic [3:0]             br_cond,
   output logic [3:0]             dest,
   output logic [3:0]             src1,
   output logic [3:0]             src2,
   output logic                   reg_write,
   output logic [DW-1:0]          imm,
   output logic                   halt,
   output logic                   mul_trigger,
   output logic [1:0]             mul_type,
   output logic [$clog2(DEPTH):0] count,
   output logic                   halted
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   rec_t          mem [DEPTH];
   rec_t          dec;
   rec_t          head;
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic [CW-1:0] cnt;
   logic          halted_q;
   logic          full;
   logic          push;
   logic          pop;

   idecode_fields u_fields (
      .instruction (instruction),
      .rec         (dec)
   );

   assign full      = (cnt == CW'(DEPTH));
   assign in_ready  = rst && !full && !halted_q && !flush;
   assign out_valid = rst && (cnt != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (!rst || flush) begin
         wptr     <= '0;
         rptr     <= '0;
         cnt      <= '0;
         halted_q <= 1'b0;
      end else begin
         if (push) wptr <= wptr + AW'(1);
         if (pop)  rptr <= rptr + AW'(1);
         case ({push, pop})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
         if (push && dec.halt) halted_q <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= dec;
   end

   assign head = out_valid ? mem[rptr] : '0;

   assign cls         = head.cls;
   assign set_flags   = head.set_flags;
   assign alu_fn      = head.alu_fn;
   assign br_cond     = head.br_cond;
   assign dest        = head.dest;
   assign src1        = head.src1;
   assign src2        = head.src2;
   assign reg_write   = head.reg_write;
   assign imm         = head.sext ? DW'($signed(head.imm)) : DW'(head.imm);
   assign halt        = head.halt;
   assign mul_trigger = head.mul_trigger;
   assign mul_type    = head.mul_type;
   assign count       = cnt;
   assign halted      = halted_q;

endmodule

// File: doc/idecode_queue.md
IDECODE_QUEUE -- requirements
Module: idecode_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning decoded-record queue depth; power of two, minimum 2.
REQ-002 SHALL have parameter DW, default 32, meaning immediate output width; minimum 16.
REQ-003 SHALL have port clk  in  1  meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  in  1  meaning synchronous, active-low reset.
REQ-005 SHALL have ports in_valid in 1, in_ready out 1, instruction in 32: the fetch handshake.
REQ-006 SHALL have port flush  in  1  meaning discard all queued records.
REQ-007 SHALL have ports out_valid out 1, out_ready in 1: the consumer handshake.
REQ-008 SHALL have head-record outputs:
- cls 2
- set_flags 1
- alu_fn 3
- br_cond 4
- dest 4
- src1 4
- src2 4
- reg_write 1
- imm DW
- halt 1
- mul_trigger 1
- mul_type 2
REQ-009 SHALL have ports count out $clog2(DEPTH)+1 (occupancy) and halted out 1.

Function
REQ-010 SHALL decode these fields:
- cls=[31:30]
- set_flags=[28]
- alu_fn=[27:25]
- dest/br_cond=[24:21]
- src1=[20:17]
- src2=[16:13]
- raw imm=[15:0]
- opcode=[31:25]
REQ-011 SHALL decode per class; fields not listed are zero:
- cls 11 (branch): br_cond, src1, src2; imm sign-extended to DW.
- cls 10 (load/store): dest, src1; imm zero-extended.
- cls 01 (data-reg): dest, src1, src2; reg_write=1.
- cls 00 (data-imm): dest, src1; imm zero-extended; reg_write=1.
REQ-012 SHALL set halt=1 when opcode==7'b1101000.
REQ-013 SHALL accept an instruction only on a cycle with in_valid&&in_ready; the accepted instruction is decoded and pushed as one record.
REQ-014 SHALL drive in_ready = !full && !halted && !flush; in_ready SHALL NOT depend on out_ready, so there is no full-queue bypass.
REQ-015 SHALL give push-to-head latency of 1 cycle: a record pushed into an empty queue is presented with out_valid=1 on the next cycle.
REQ-016 SHALL pop on a cycle with out_valid&&out_ready.
REQ-017 SHALL keep count unchanged on a simultaneous push and pop.
REQ-018 SHALL wrap pointers modulo DEPTH.
REQ-019 SHALL drive all head-record outputs to 0 while the queue is empty.
REQ-020 SHALL set the sticky halted flag on the cycle after a halt record is accepted; the halt record itself is queued normally.
REQ-021 SHALL give flush priority over push and pop on the same cycle; flush empties the queue, zeroes count and clears halted on the next cycle.
REQ-022 SHALL hold head-record outputs stable while out_valid=1 and out_ready=0.

Reset
REQ-023 SHALL, when rst=0 at a clock edge, zero the pointers, count and halted flag; out_valid=0, all head outputs=0 and in_ready=0 during reset.
REQ-024 SHALL abandon any in-progress handshake on reset mid-operation; no record survives reset.

Configuration
REQ-025 SHALL compile multiply decode in only when IDECODE_MUL_EN is defined; opcode -> mul_trigger=1 and mul_type:
- 7'b0010000 -> 0
- 7'b0110000 -> 1
- 7'b0011000 -> 2
- 7'b0111000 -> 3
REQ-026 SHALL, without IDECODE_MUL_EN, tie mul_trigger and mul_type to 0; those opcodes decode as ordinary cls 00/01 records.

Structure
REQ-027 SHALL place these in shared package idecode_pkg:
- class encodings
- halt and multiply opcode constants
- the decoded-record typedef
REQ-028 SHALL contain one purely combinational sub-module idecode_fields (instruction -> record); storage and control stay in idecode_queue.

Verification
REQ-029 SHALL cover: empty queue, push 32'h0A4A_8005 (cls 00) -> next cycle out_valid=1, dest=2, src1=5, imm=32'h0000_8005, reg_write=1.
REQ-030 SHALL cover: branch 32'hC020_0FFF with imm[15]=0, then 32'hC020_8000 -> imm 32'h0000_0FFF then 32'hFFFF_8000.
REQ-031 SHALL cover: out_ready=0, DEPTH=4, push 5 back-to-back -> 4 accepted, count=4, in_ready=0, 5th held until a pop.
REQ-032 SHALL cover: halt 32'hD000_0000 accepted -> halted=1 next cycle, in_ready=0; halt record popped with halt=1; flush -> halted=0, count=0.
REQ-033 SHALL cover: count=2 with push, pop and flush on the same cycle -> count=0, out_valid=0 next cycle.
REQ-034 SHALL cover: with IDECODE_MUL_EN, 32'h7000_0000 -> mul_trigger=1, mul_type=3; without it -> mul_trigger=0, cls=01.
